serial_subtractor: RTL

Bit-serial two's-complement subtractor that computes a − b one bit per clock, LSB first, using a single full-subtractor cell with a registered borrow. It is the inverse-operation companion to the combinational adder cells: it trades latency for area in datapaths where a WIDTH-bit parallel subtractor is too large. Operands are loaded with a start/done handshake. Results stay stable between operations.

---
 rtl/serial_subtractor.sv | 129 ++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial two's-complement subtractor. It computes a - b one bit
//            per clock, LSB first, using one full-subtractor cell and a
//            registered borrow. Operands are loaded with a start/done
//            handshake. Results stay stable between operations.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            start  - request a subtraction (sampled only in IDLE)
//            a, b   - minuend / subtrahend, captured on the accepting edge
//            busy   - high while bits are being processed
//            done   - one-cycle pulse; results valid from this cycle on
//            diff   - a - b modulo 2^WIDTH
//            bout   - unsigned borrow out (a < b)
//            ovf    - signed overflow of the subtraction
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int c_CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    // Holds only the WIDTH-1 most recent difference bits. The final bit comes
    // straight from the cell on the completion edge, so no bit is stored
    // that is never read.
    logic [WIDTH-2:0] r_res;
    logic             r_br;
    logic [c_CW-1:0]  r_cnt;
    logic             r_sign_a;
    logic             r_sign_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    logic             w_d;
    logic             w_br_next;
    logic             w_last;
    logic [WIDTH-1:0] w_shift;

    // Full-subtractor cell on the current LSBs
    assign w_d       = r_sa[0] ^ r_sb[0] ^ r_br;
    assign w_br_next = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
    assign w_last    = (r_cnt == c_CNT_LAST);
    // Result register after shifting the new bit into its MSB
    assign w_shift   = {w_d, r_res};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_res    <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_sa     <= a;
                        r_sb     <= b;
                        r_br     <= 1'b0;
                        r_cnt    <= '0;
                        r_sign_a <= a[WIDTH-1];
                        r_sign_b <= b[WIDTH-1];
                        r_state  <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_br  <= w_br_next;
                    r_res <= w_shift[WIDTH-1:1];
                    if (w_last) begin
                        // Counter is parked at zero instead of wrapping
                        r_cnt   <= '0;
                        r_diff  <= w_shift;
                        r_bout  <= w_br_next;
                        r_ovf   <= (r_sign_a ^ r_sign_b) & (w_d ^ r_sign_a);
                        r_state <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == c_RUN);
    assign done = (r_state == c_DONE);
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire
